// File: rtl/risc_pkg.sv
// Shared register-file constants and the write-back entry type.
package risc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] value;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back buffer: storage, pointers, occupancy count and status flags.
module wb_fifo
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output wb_entry_t                entries_o [DEPTH],
  output logic [DEPTH-1:0]         valid_o,
  output logic [$clog2(DEPTH)-1:0] rptr_o,
  output logic [$clog2(DEPTH)-1:0] wptr_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = push_i ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop_i ? rptr_q + PtrW'(1) : rptr_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push_i) begin
        mem_q[wptr_q] <= push_entry_i;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin : valid_scan
    logic [PtrW-1:0] off;
    off     = '0;
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off        = PtrW'(i) - rptr_q;
      valid_o[i] = {1'b0, off} < cnt_q;
    end
  end

  assign entries_o = mem_q;
  assign rptr_o    = rptr_q;
  assign wptr_o    = wptr_q;
  assign full_o    = (cnt_q == CntW'(DEPTH));
  assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/writeback_unit.sv
// Write-side front end: arbitrates ALU/load results into the buffer, drains it to the
// register-file write port, and forwards the youngest buffered value for two sources.
module writeback_unit #(
  parameter int unsigned DATA_W = risc_pkg::DATA_W,
  parameter int unsigned ADDR_W = risc_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_value,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_value,
  input  logic              wb_stall,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] rd_value,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic [DATA_W-1:0] rs1_fwd_value,
  output logic [DATA_W-1:0] rs2_fwd_value,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  risc_pkg::wb_entry_t entries [DEPTH];
  risc_pkg::wb_entry_t push_entry;
  risc_pkg::wb_entry_t head;
  logic [DEPTH-1:0]    valid;
  logic [PtrW-1:0]     rptr, wptr;
  logic                push;

  // No bypass: a full buffer refuses even when the head drains this edge.
  assign mem_ready = !full && !rst;
  assign alu_ready = !full && !mem_valid && !rst;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);

  always_comb begin
    push_entry.rd    = mem_valid ? mem_rd : alu_rd;
    push_entry.value = mem_valid ? mem_value : alu_value;
  end

  assign reg_write_en = !empty && !wb_stall;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (reg_write_en),
    .entries_o   (entries),
    .valid_o     (valid),
    .rptr_o      (rptr),
    .wptr_o      (wptr),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign head     = entries[rptr];
  assign rd       = empty ? '0 : head.rd;
  assign rd_value = empty ? '0 : head.value;

  // Walk backwards from the newest slot so the first hit is the youngest writer.
  function automatic logic [DATA_W:0] fwd_scan(input logic [ADDR_W-1:0] rs);
    logic              hit;
    logic [DATA_W-1:0] val;
    logic [PtrW-1:0]   idx;
    hit = 1'b0;
    val = '0;
    idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = wptr - PtrW'(k + 1);
      if (!hit && valid[idx] && (entries[idx].rd == rs)) begin
        hit = 1'b1;
        val = entries[idx].value;
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    {rs1_pending, rs1_fwd_value} = fwd_scan(rs1);
    {rs2_pending, rs2_fwd_value} = fwd_scan(rs2);
  end

endmodule
